bcd_converter: RTL
==================

# bcd_converter

Sequential binary-to-BCD converter (shift-and-add-3) that sits between the countdown timer and the seven-segment digit decoders. It converts the timer's binary seconds count into decimal digits, so the display reads 120 rather than 0x78. Conversion is started by a one-cycle request and finishes with a one-cycle completion pulse. Results are registered and held between conversions.

## Interface
- `WIDTH`, 8: width of the binary input, in bits.
- `DIGITS`, 3: number of BCD digits produced (4 bits each).
- `Clock` in 1: system clock (CLOCK_50 at top level).
- `Reset` in 1: synchronous, active-high reset.
- `Start` in 1: conversion request; sampled only in IDLE.
- `BinIn` in WIDTH: unsigned binary value; captured on the cycle Start is accepted.
- `BcdOut` out 4*DIGITS: packed BCD result. Digit 0 (ones) is [3:0]; digit k is [4k+3:4k].
- `Busy` out 1: high while a conversion is in progress.
- `Done` out 1: one-cycle pulse when BcdOut is updated.
- `Overflow` out 1: high when the last converted value exceeded 10^DIGITS−1.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - If Start=1, load shift register ← BinIn, load scratch BCD ← 0, load bit counter ← WIDTH, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - Every scratch digit ≥ 5 gets +3.
  - Then {scratch, shift} is shifted left by 1.
  - Counter decrements.
  - When counter reaches 1 in this cycle (the last shift), go to DONE.
- DONE:
  - BcdOut ← final scratch, Done=1, Overflow updated.
  - Return to IDLE next cycle.
- Overflow rule:
  - Overflow=1 if the captured BinIn > 10^DIGITS−1. Compare against a constant derived from DIGITS.
  - On overflow, BcdOut saturates to all nines (e.g. DIGITS=2 gives 0x99).
  - Overflow is cleared by the next non-overflowing conversion.
  - Scratch register is DIGITS+1 digits wide internally, so overflow never corrupts the arithmetic.
- Start while Busy or in DONE is ignored, not queued.
- BinIn changes after capture have no effect on the conversion in progress.
- Width rules:
  - Scratch digits are 4-bit.
  - The add-3 is applied only to digits ≥ 5, so no digit ever exceeds 9 after the shift.
  - Counter width is clog2(WIDTH+1).

## Timing
- Reset values: BcdOut=0, Busy=0, Done=0, Overflow=0, state=IDLE.
- Reset has priority over every other event. A reset mid-conversion aborts it, with no Done pulse and BcdOut forced to 0.
- Start accepted at edge N:
  - Busy=1 from cycle N+1 through cycle N+WIDTH (WIDTH SHIFT cycles).
  - Cycle N+WIDTH+1 is DONE: Done=1, Busy=0, BcdOut and Overflow valid from this cycle.
  - Latency is WIDTH+1 cycles from accepted Start to Done.
- Throughput: the earliest next Start is accepted in IDLE at cycle N+WIDTH+2, giving one conversion per WIDTH+2 cycles.
- BcdOut and Overflow are stable at all times except the DONE-cycle update. The consumer may read them continuously (no glitch, all registered).
- Start held high continuously gives back-to-back conversions every WIDTH+2 cycles.

## Structure
- Shared package `b58_pkg` holds:
  - the `conv_state_t` enum (IDLE, SHIFT, DONE);
  - `BCD_DIGIT_W` = 4;
  - the `BCD_NINE` constant;
  - a function computing 10^DIGITS−1 for the overflow limit.
- Natural sub-module: `bcd_digit_adjust`, a combinational 4-bit "if ≥5 then +3" cell, instantiated DIGITS+1 times via generate.
- Top level drives Start from the timer's one-second tick (RateDivider output, delayed one cycle). It maps BcdOut digits to HEX0/HEX1/HEX2 through the existing hex decoders.

## Test plan
- Reset, then Start with BinIn=120 (WIDTH=8, DIGITS=3): Done pulses exactly 9 cycles after Start, BcdOut=0x120, Overflow=0, and Busy is high for 8 cycles.
- BinIn=0 then BinIn=255, back-to-back with Start held high: results 0x000 then 0x255, Done pulses 10 cycles apart, no intermediate glitch on BcdOut.
- DIGITS=2, BinIn=120: BcdOut=0x99, Overflow=1. A following BinIn=42 gives BcdOut=0x42 with Overflow=0.
- Pulse Start again 3 cycles into a conversion of 59 while BinIn is changed to 7: the second Start is ignored, one Done pulse only, BcdOut=0x059.
- Assert Reset in the 5th SHIFT cycle of converting 200: no Done pulse, BcdOut=0, Busy=0. A Start two cycles after reset release converts 200 → 0x200 normally.
- Sweep all BinIn values 0–255 against a reference model: every digit is ≤ 9 and the decimal value matches.

Source files
------------

// File: rtl/b58_pkg.sv
// Shared types and constants for the binary-to-BCD conversion path.
// Holds the converter FSM encoding, digit constants and the overflow-limit helper.
package b58_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic int unsigned bcd_limit(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble digit cell: adds 3 to a BCD digit of 5 or more.
// Applied before each left shift so the shifted digit never exceeds 9.
module bcd_digit_adjust
  import b58_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, WIDTH+1 cycles from Start to Done.
// Start is ignored while busy or done; results are registered and held until the next conversion.
module bcd_converter
  import b58_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [WIDTH-1:0]              i_bin_in,
  output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd_out,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_overflow
);

  localparam int SW = BCD_DIGIT_W * (DIGITS + 1);
  localparam int OW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [31:0] LIMIT = 32'(bcd_limit(DIGITS));
  localparam logic [OW-1:0] SAT = {DIGITS{BCD_NINE}};

  conv_state_t   r_state;
  conv_state_t   w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_bin;
  logic [SW-1:0] r_scratch;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_bcd;
  logic          r_ovf;

  logic [SW-1:0] w_adj;
  logic [SW-1:0] w_scratch_next;
  logic          w_last;
  logic          w_ovf;

  // One spare digit above the output width keeps out-of-range inputs from wrapping.
  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit(r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit(w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_scratch_next = {w_adj[SW-2:0], r_shift[WIDTH-1]};
  assign w_last         = (r_cnt == CW'(1));
  assign w_ovf          = (32'(r_bin) > LIMIT);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = SHIFT;
      SHIFT:   if (w_last)  w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_shift   <= i_bin_in;
            r_bin     <= i_bin_in;
            r_scratch <= '0;
            r_cnt     <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          r_scratch <= w_scratch_next;
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt - CW'(1);
          // Results land on the last shift so they are valid during the DONE cycle.
          if (w_last) begin
            r_ovf <= w_ovf;
            r_bcd <= w_ovf ? SAT : w_scratch_next[OW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bcd_out  = r_bcd;
  assign o_overflow = r_ovf;
  assign o_busy     = (r_state == SHIFT);
  assign o_done     = (r_state == DONE);

endmodule
